// File: rtl/irq_arbiter.sv
// irq_arbiter: centralised fixed-priority interrupt arbiter for the TW4 CPU.
// Synchronises raw button lines, latches rising edges as pending requests,
// masks them with the CPU enables and presents one request at a time on irq
// with a stable vector, retiring it on the CPU acknowledge.
//
// Ports:
//   clock    in   system clock, rising edge
//   reset    in   asynchronous active-low reset
//   in       in   [N]  raw asynchronous button levels
//   ie       in   [N]  per-source interrupt enable (clock domain)
//   ack      in   one-cycle acknowledge of the presented request
//   irq      out  request to the CPU (registered)
//   vector   out  [VW] index of the presented source, 0 when irq is low
//   pending  out  [N]  latched unserviced edges, unmasked
//   overrun  out  one-cycle pulse: edge on an already pending source
module irq_arbiter #(
   parameter int unsigned N           = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned VW          = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [N-1:0]  in,
   input  logic [N-1:0]  ie,
   input  logic          ack,
   output logic          irq,
   output logic [VW-1:0] vector,
   output logic [N-1:0]  pending,
   output logic          overrun
);

   // Edges are ignored until both the synchroniser output and its delayed
   // copy hold post-reset samples, so lines already high at release are quiet.
   localparam int unsigned   FillMax  = SYNC_STAGES + 1;
   localparam int unsigned   FW       = $clog2(FillMax + 1);
   localparam logic [FW-1:0] FillDone = FW'(FillMax);

   typedef enum logic [1:0] {StIdle, StReq, StGap} state_e;

   logic [N-1:0]  sync_q [SYNC_STAGES];
   logic [N-1:0]  prev_q;
   logic [FW-1:0] fill_q;
   logic [N-1:0]  pending_q;
   logic          overrun_q;
   state_e        state_q;
   logic [VW-1:0] vec_q;
   logic          irq_q;
   logic [VW-1:0] vector_q;

   logic [N-1:0]  s;
   logic          filled;
   logic [N-1:0]  edge_det;
   logic [N-1:0]  clr;
   logic [N-1:0]  eligible;
   logic          win_valid;
   logic [VW-1:0] win_idx;
   logic          accept;

   // Input synchroniser
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= '0;
         end
      end else begin
         sync_q[0] <= in;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         prev_q <= '0;
         fill_q <= '0;
      end else begin
         prev_q <= s;
         if (fill_q != FillDone) begin
            fill_q <= fill_q + 1'b1;
         end
      end
   end

   assign filled   = (fill_q == FillDone);
   assign edge_det = filled ? (s & ~prev_q) : '0;

   // Only an ack while presenting retires the presented source.
   assign accept = (state_q == StReq) && ack;
   assign clr    = accept ? (N'(1) << vec_q) : '0;

   // Set wins over a simultaneous clear; overrun only when the edge is lost.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pending_q <= '0;
         overrun_q <= 1'b0;
      end else begin
         pending_q <= (pending_q & ~clr) | edge_det;
         overrun_q <= |(edge_det & pending_q & ~clr);
      end
   end

   assign eligible = pending_q & ie;

   // Lowest index wins: scan downwards so the last hit is the lowest.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            win_valid = 1'b1;
            win_idx   = VW'(i);
         end
      end
   end

   // Presentation FSM with registered irq/vector.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         vec_q    <= '0;
         irq_q    <= 1'b0;
         vector_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (win_valid) begin
                  state_q  <= StReq;
                  vec_q    <= win_idx;
                  irq_q    <= 1'b1;
                  vector_q <= win_idx;
               end
            end
            StReq: begin
               if (ack) begin
                  state_q  <= StGap;
                  irq_q    <= 1'b0;
                  vector_q <= '0;
               end else if (!ie[vec_q]) begin
                  // Withdraw; the request stays pending.
                  state_q  <= StIdle;
                  irq_q    <= 1'b0;
                  vector_q <= '0;
               end
            end
            StGap: begin
               state_q <= StIdle;
            end
            default: begin
               state_q  <= StIdle;
               irq_q    <= 1'b0;
               vector_q <= '0;
            end
         endcase
      end
   end

   assign irq     = irq_q;
   assign vector  = vector_q;
   assign pending = pending_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter: directed scenarios plus randomized stimulus checked against
// a cycle-level behavioural model of the interrupt arbiter.
module tb_irq_arbiter;

   localparam int N    = 4;
   localparam int SYNC = 2;
   localparam int VW   = 2;
   localparam int OW   = VW + N + 2;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic [N-1:0]  din   = '0;
   logic [N-1:0]  ie    = '0;
   logic          ack   = 1'b0;
   logic          irq;
   logic [VW-1:0] vector;
   logic [N-1:0]  pending;
   logic          overrun;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   irq_arbiter #(.N(N), .SYNC_STAGES(SYNC), .VW(VW)) dut (
      .clock   (clock),
      .reset   (reset),
      .in      (din),
      .ie      (ie),
      .ack     (ack),
      .irq     (irq),
      .vector  (vector),
      .pending (pending),
      .overrun (overrun)
   );

   always #5 clock = ~clock;

   // Behavioural model: hist[j] is the input sampled j edges ago; an event is
   // seen SYNC edges after sampling. m_cur is the presented source or -1.
   logic [N-1:0] hist [0:SYNC+1];
   logic [N-1:0] m_pend;
   logic [N-1:0] m_edge;
   logic [N-1:0] m_clr;
   logic [N-1:0] m_elig;
   logic         m_ovr;
   int           m_cur;
   bit           m_gap;
   int           m_age;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int j = 0; j <= SYNC + 1; j++) hist[j] = '0;
         m_pend = '0;
         m_ovr  = 1'b0;
         m_cur  = -1;
         m_gap  = 1'b0;
         m_age  = 0;
      end else begin
         m_edge = (m_age >= SYNC + 1) ? (hist[SYNC] & ~hist[SYNC+1]) : '0;
         m_clr  = '0;
         if (m_cur >= 0 && ack) m_clr[m_cur] = 1'b1;
         m_elig = m_pend & ie;
         m_ovr  = |(m_edge & m_pend & ~m_clr);
         if (m_gap) begin
            m_gap = 1'b0;
         end else if (m_cur >= 0) begin
            if (ack) begin
               m_cur = -1;
               m_gap = 1'b1;
            end else if (!ie[m_cur]) begin
               m_cur = -1;
            end
         end else begin
            for (int i = N - 1; i >= 0; i--) if (m_elig[i]) m_cur = i;
         end
         m_pend = (m_pend & ~m_clr) | m_edge;
         for (int j = SYNC + 1; j > 1; j--) hist[j] = hist[j-1];
         hist[1] = din;
         if (m_age < 100) m_age++;
      end
   end

   function automatic logic [OW-1:0] model_out();
      logic [VW-1:0] v;
      v = (m_cur >= 0) ? VW'(m_cur) : '0;
      return {(m_cur >= 0), v, m_pend, m_ovr};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      tick();
      chk_cnt++;
      if ({irq, vector, pending, overrun} !== '0)
         $display("FAIL reset_state: got %h required 0", {irq, vector, pending, overrun});
      else pass_cnt++;
      @(negedge clock);
      reset = 1'b1;
      repeat (5) tick();
      chk_cnt++;
      if (irq !== 1'b0) $display("FAIL reset_idle: irq got %b required 0", irq);
      else pass_cnt++;
   endtask

   task automatic test_single();
      ie = 4'hF;
      @(negedge clock);
      din[2] = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         tick();
         if (c == 3) begin
            chk_cnt++;
            if (pending !== 4'b0100 || irq !== 1'b0)
               $display("FAIL single_pend: pending %b irq %b required 0100 0", pending, irq);
            else pass_cnt++;
         end
         if (c == 4) begin
            chk_cnt++;
            if (irq !== 1'b1 || vector !== 2'd2)
               $display("FAIL single_irq: irq %b vector %0d required 1 2", irq, vector);
            else pass_cnt++;
         end
      end
      tick();
      @(negedge clock);
      din[2] = 1'b0;
      ack = 1'b1;
      tick();
      chk_cnt++;
      if (pending !== 4'b0000 || irq !== 1'b0)
         $display("FAIL single_ack: pending %b irq %b required 0000 0", pending, irq);
      else pass_cnt++;
      @(negedge clock);
      ack = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_priority();
      ie = 4'hF;
      @(negedge clock);
      din = 4'b1010;
      repeat (4) tick();
      chk_cnt++;
      if (irq !== 1'b1 || vector !== 2'd1)
         $display("FAIL prio_first: irq %b vector %0d required 1 1", irq, vector);
      else pass_cnt++;
      @(negedge clock);
      din = '0;
      ack = 1'b1;
      tick();
      @(negedge clock);
      ack = 1'b0;
      tick();
      chk_cnt++;
      if (irq !== 1'b0) $display("FAIL prio_gap: irq %b required 0", irq);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (irq !== 1'b1 || vector !== 2'd3)
         $display("FAIL prio_second: irq %b vector %0d required 1 3", irq, vector);
      else pass_cnt++;
      @(negedge clock);
      ack = 1'b1;
      tick();
      @(negedge clock);
      ack = 1'b0;
      repeat (2) tick();
      chk_cnt++;
      if (irq !== 1'b0 || pending !== 4'b0000)
         $display("FAIL prio_idle: irq %b pending %b required 0 0000", irq, pending);
      else pass_cnt++;
   endtask

   task automatic test_mask_withdraw();
      ie = 4'h0;
      @(negedge clock);
      din[0] = 1'b1;
      repeat (4) tick();
      @(negedge clock);
      din[0] = 1'b0;
      tick();
      chk_cnt++;
      if (pending !== 4'b0001 || irq !== 1'b0)
         $display("FAIL mask_hold: pending %b irq %b required 0001 0", pending, irq);
      else pass_cnt++;
      @(negedge clock);
      ie = 4'b0001;
      tick();
      chk_cnt++;
      if (irq !== 1'b1 || vector !== 2'd0)
         $display("FAIL mask_enable: irq %b vector %0d required 1 0", irq, vector);
      else pass_cnt++;
      @(negedge clock);
      ie = 4'b0000;
      tick();
      chk_cnt++;
      if (irq !== 1'b0 || pending !== 4'b0001)
         $display("FAIL withdraw: irq %b pending %b required 0 0001", irq, pending);
      else pass_cnt++;
      @(negedge clock);
      ie = 4'hF;
      tick();
      @(negedge clock);
      ack = 1'b1;
      tick();
      @(negedge clock);
      ack = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_overrun_set_wins();
      bit seen;
      ie = 4'h0;
      @(negedge clock);
      din[1] = 1'b1;
      repeat (4) tick();
      @(negedge clock);
      din[1] = 1'b0;
      repeat (4) tick();
      @(negedge clock);
      din[1] = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (overrun) seen = 1'b1;
      end
      chk_cnt++;
      if (seen !== 1'b1 || pending !== 4'b0010)
         $display("FAIL overrun: seen %b pending %b required 1 0010", seen, pending);
      else pass_cnt++;
      @(negedge clock);
      din[1] = 1'b0;
      repeat (4) tick();
      @(negedge clock);
      ie = 4'b0010;
      tick();
      chk_cnt++;
      if (irq !== 1'b1 || vector !== 2'd1)
         $display("FAIL setwin_present: irq %b vector %0d required 1 1", irq, vector);
      else pass_cnt++;
      @(negedge clock);
      din[1] = 1'b1;
      tick();
      tick();
      @(negedge clock);
      ack = 1'b1;
      tick();
      chk_cnt++;
      if (pending[1] !== 1'b1 || irq !== 1'b0 || overrun !== 1'b0)
         $display("FAIL setwin_keep: pend1 %b irq %b ovr %b required 1 0 0",
                  pending[1], irq, overrun);
      else pass_cnt++;
      @(negedge clock);
      ack = 1'b0;
      tick();
      chk_cnt++;
      if (irq !== 1'b0) $display("FAIL setwin_gap: irq %b required 0", irq);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (irq !== 1'b1 || vector !== 2'd1)
         $display("FAIL setwin_reassert: irq %b vector %0d required 1 1", irq, vector);
      else pass_cnt++;
      @(negedge clock);
      din[1] = 1'b0;
      ack = 1'b1;
      tick();
      @(negedge clock);
      ack = 1'b0;
      ie = 4'hF;
      repeat (3) tick();
   endtask

   task automatic test_spurious_no_preempt();
      bit held;
      ie = 4'hF;
      @(negedge clock);
      ack = 1'b1;
      tick();
      @(negedge clock);
      ack = 1'b0;
      tick();
      chk_cnt++;
      if (irq !== 1'b0 || pending !== 4'b0000)
         $display("FAIL spurious_ack: irq %b pending %b required 0 0000", irq, pending);
      else pass_cnt++;
      @(negedge clock);
      din[2] = 1'b1;
      repeat (4) tick();
      @(negedge clock);
      din[2] = 1'b0;
      din[0] = 1'b1;
      held = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (irq !== 1'b1 || vector !== 2'd2) held = 1'b0;
      end
      chk_cnt++;
      if (held !== 1'b1 || pending !== 4'b0101)
         $display("FAIL no_preempt: held %b pending %b required 1 0101", held, pending);
      else pass_cnt++;
      @(negedge clock);
      din[0] = 1'b0;
      ack = 1'b1;
      tick();
      @(negedge clock);
      ack = 1'b0;
      repeat (2) tick();
      chk_cnt++;
      if (irq !== 1'b1 || vector !== 2'd0)
         $display("FAIL after_preempt: irq %b vector %0d required 1 0", irq, vector);
      else pass_cnt++;
      @(negedge clock);
      ack = 1'b1;
      tick();
      @(negedge clock);
      ack = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_random();
      int bad = 0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clock);
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(5) == 0) din[i] = ~din[i];
            if ($urandom_range(7) == 0) ie[i] = ~ie[i];
         end
         ack = ($urandom_range(2) == 0);
         tick();
         chk_cnt++;
         if ({irq, vector, pending, overrun} !== model_out()) begin
            if (bad < 10)
               $display("FAIL random_model cycle %0d: got %b required %b", c,
                        {irq, vector, pending, overrun}, model_out());
            bad++;
         end else pass_cnt++;
      end
      @(negedge clock);
      din = '0;
      ie  = 4'hF;
      for (int c = 0; c < 30; c++) begin
         @(negedge clock);
         ack = irq;
         tick();
      end
      @(negedge clock);
      ack = 1'b0;
      tick();
      chk_cnt++;
      if (pending !== 4'b0000 || irq !== 1'b0)
         $display("FAIL random_drain: pending %b irq %b required 0000 0", pending, irq);
      else pass_cnt++;
   endtask

   task automatic test_async_reset();
      bit got = 1'b0;
      bit quiet = 1'b1;
      ie = 4'hF;
      @(negedge clock);
      din[0] = 1'b1;
      for (int c = 0; c < 8 && !got; c++) begin
         tick();
         if (irq === 1'b1) got = 1'b1;
      end
      chk_cnt++;
      if (!got) $display("FAIL reset_setup: irq never rose, got 0 required 1");
      else pass_cnt++;
      #1;
      reset = 1'b0;
      #1;
      chk_cnt++;
      if ({irq, vector, pending, overrun} !== '0)
         $display("FAIL async_reset: got %h required 0", {irq, vector, pending, overrun});
      else pass_cnt++;
      @(negedge clock);
      reset = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (irq !== 1'b0 || pending !== 4'b0000) quiet = 1'b0;
      end
      chk_cnt++;
      if (quiet !== 1'b1)
         $display("FAIL release_no_edge: quiet %b required 1", quiet);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_priority();
      test_mask_withdraw();
      test_overrun_set_wins();
      test_spurious_no_preempt();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
